// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: FIFO entry layout, FSM states
// and the default reset PC.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    FS_RUN,
    FS_WAIT_REDIRECT
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Instruction FIFO: DEPTH entries of {instr, pc}, synchronous push/pop/flush.
// Flush wins over a same-edge push so a word arriving with the flush is discarded.
module fetch_unit_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // NOTE: storage carries no reset; an entry is only read once the pointers mark it valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: non-blocking assignments for every register so all state updates on the same edge.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited in-order reads, FIFO of {word, pc}
// toward the decoder, and a freeze until execute redirects after control flow.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IMEM_REQ_VALID,
  input  logic        IMEM_REQ_READY,
  output logic [31:0] IMEM_REQ_ADDR,
  input  logic        IMEM_RESP_VALID,
  input  logic [31:0] IMEM_RESP_DATA,
  input  logic        STALL,
  output logic        DECODER_ENABLED,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC,
  input  logic        CONDITIONAL_JUMP,
  input  logic        REDIRECT_VALID,
  input  logic [31:0] REDIRECT_PC,
  output logic        BUSY_WAIT
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   tag_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] count;
  logic [CW:0]   used;
  logic          empty;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          req_accept;
  logic          resp_drop;
  logic          resp_keep;
  logic          jump;

  // Credits cover both buffered words and reads still in flight, so a push never overflows.
  assign used            = {1'b0, count} + {1'b0, outstanding};
  assign IMEM_REQ_VALID  = !RST && (state == FS_RUN) && (used < (CW+1)'(DEPTH));
  assign IMEM_REQ_ADDR   = {fetch_pc[31:2], 2'b00};
  assign DECODER_ENABLED = !RST && (state == FS_RUN) && !empty && !STALL;
  assign INSTRUCTION     = empty ? 32'h0 : head.instr;
  assign PC              = empty ? 32'h0 : head.pc;
  assign BUSY_WAIT       = (state == FS_WAIT_REDIRECT);

  assign req_accept = IMEM_REQ_VALID && IMEM_REQ_READY;
  assign resp_drop  = IMEM_RESP_VALID && (drop != '0);
  assign resp_keep  = IMEM_RESP_VALID && (drop == '0);
  assign jump       = DECODER_ENABLED && CONDITIONAL_JUMP;
  assign push_entry = '{instr: IMEM_RESP_DATA, pc: tag_pc};

  assign outstanding_next = outstanding + CW'(req_accept) - CW'(IMEM_RESP_VALID);

  fetch_unit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (resp_keep),
    .push_data (push_entry),
    .pop       (DECODER_ENABLED),
    .flush     (jump),
    .head      (head),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= FS_RUN;
      fetch_pc    <= RESET_PC;
      tag_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (req_accept) fetch_pc <= fetch_pc + 32'd4;
      if (resp_keep)  tag_pc   <= tag_pc + 32'd4;
      unique case (state)
        FS_RUN: begin
          // Everything still in flight after this edge belongs to the abandoned path.
          if (jump) begin
            state <= FS_WAIT_REDIRECT;
            drop  <= outstanding_next;
          end else begin
            drop  <= drop - CW'(resp_drop);
          end
        end
        FS_WAIT_REDIRECT: begin
          drop <= drop - CW'(resp_drop);
          if (REDIRECT_VALID) begin
            state    <= FS_RUN;
            fetch_pc <= {REDIRECT_PC[31:2], 2'b00};
            tag_pc   <= {REDIRECT_PC[31:2], 2'b00};
          end
        end
        default: state <= FS_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: bench-side memory model plus a scoreboard of
// expected {instr, pc} handovers derived from the program flow.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IMEM_REQ_VALID;
  logic        IMEM_REQ_READY;
  logic [31:0] IMEM_REQ_ADDR;
  logic        IMEM_RESP_VALID;
  logic [31:0] IMEM_RESP_DATA;
  logic        STALL;
  logic        DECODER_ENABLED;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC;
  logic        CONDITIONAL_JUMP;
  logic        REDIRECT_VALID;
  logic [31:0] REDIRECT_PC;
  logic        BUSY_WAIT;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .IMEM_REQ_VALID   (IMEM_REQ_VALID),
    .IMEM_REQ_READY   (IMEM_REQ_READY),
    .IMEM_REQ_ADDR    (IMEM_REQ_ADDR),
    .IMEM_RESP_VALID  (IMEM_RESP_VALID),
    .IMEM_RESP_DATA   (IMEM_RESP_DATA),
    .STALL            (STALL),
    .DECODER_ENABLED  (DECODER_ENABLED),
    .INSTRUCTION      (INSTRUCTION),
    .PC               (PC),
    .CONDITIONAL_JUMP (CONDITIONAL_JUMP),
    .REDIRECT_VALID   (REDIRECT_VALID),
    .REDIRECT_PC      (REDIRECT_PC),
    .BUSY_WAIT        (BUSY_WAIT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t        mem_q[$];
  fetch_entry_t exp_q[$];

  int          nvec = 0;
  int          nfail = 0;
  int          cyc, lat, redir_delay, redir_cycle, req_chk_cycle, busy_cnt, ho;
  bit          stall, rand_ready, jump_armed, chk_ahead, prev_stalled, want_first;
  logic [31:0] jump_pc, jump_tgt, prev_addr, first_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_from(input logic [31:0] start, input int n);
    logic [31:0] p = start;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{instr: mem_word(p), pc: p});
      p += 32'd4;
    end
  endtask

  // One clock cycle per iteration, entered and left at the falling edge.
  task automatic run_cycles(input int n);
    fetch_entry_t e;
    for (int i = 0; i < n; i++) begin
      STALL          = stall;
      IMEM_REQ_READY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        IMEM_RESP_VALID = 1'b1;
        IMEM_RESP_DATA  = mem_word(mem_q[0].addr);
        void'(mem_q.pop_front());
      end else begin
        IMEM_RESP_VALID = 1'b0;
        IMEM_RESP_DATA  = 32'h0;
      end
      REDIRECT_VALID   = (cyc == redir_cycle);
      REDIRECT_PC      = jump_tgt;
      CONDITIONAL_JUMP = 1'b0;
      #1;
      CONDITIONAL_JUMP = jump_armed && (PC === jump_pc);
      #1;
      if (STALL) check("stall_hold", 32'(DECODER_ENABLED), 32'd0);
      if (chk_ahead && IMEM_REQ_VALID && exp_q.size() > 0)
        check("ahead_bound", 32'((IMEM_REQ_ADDR - exp_q[0].pc) < 32'(4 * DEPTH)), 32'd1);
      if (prev_stalled && IMEM_REQ_VALID) check("addr_stable", IMEM_REQ_ADDR, prev_addr);
      if (cyc == req_chk_cycle) begin
        check("redir_req_valid", 32'(IMEM_REQ_VALID), 32'd1);
        check("redir_req_addr", IMEM_REQ_ADDR, jump_tgt);
      end
      if (BUSY_WAIT) busy_cnt++;
      if (DECODER_ENABLED) begin
        ho++;
        if (want_first) begin
          first_pc   = PC;
          want_first = 1'b0;
        end
        nvec++;
        assert (exp_q.size() > 0) else begin
          nfail++;
          $error("FAIL extra_handover: observed pc %h expected none", PC);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("handover_pc", PC, e.pc);
          check("handover_instr", INSTRUCTION, e.instr);
        end
        if (CONDITIONAL_JUMP) begin
          exp_q.delete();
          expect_from(jump_tgt, 200);
          redir_cycle   = cyc + redir_delay;
          req_chk_cycle = redir_cycle + 1;
          jump_armed    = 1'b0;
          want_first    = 1'b1;
        end
      end
      prev_stalled = IMEM_REQ_VALID && !IMEM_REQ_READY;
      prev_addr    = IMEM_REQ_ADDR;
      if (IMEM_REQ_VALID && IMEM_REQ_READY) mem_q.push_back('{IMEM_REQ_ADDR, cyc + lat});
      @(posedge CLK);
      @(negedge CLK);
      cyc++;
    end
  endtask

  // Memory shares the reset, so its pending responses vanish with it.
  task automatic do_reset();
    RST = 1'b1; STALL = 1'b0; IMEM_REQ_READY = 1'b0; IMEM_RESP_VALID = 1'b0;
    IMEM_RESP_DATA = 32'h0; CONDITIONAL_JUMP = 1'b0; REDIRECT_VALID = 1'b0; REDIRECT_PC = 32'h0;
    @(posedge CLK);
    @(negedge CLK);
    #1;
    check("rst_req_valid", 32'(IMEM_REQ_VALID), 32'd0);
    check("rst_dec_en", 32'(DECODER_ENABLED), 32'd0);
    check("rst_busy", 32'(BUSY_WAIT), 32'd0);
    check("rst_instr", INSTRUCTION, 32'h0);
    check("rst_pc", PC, 32'h0);
    check("rst_addr", IMEM_REQ_ADDR, 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    mem_q.delete(); exp_q.delete();
    expect_from(RESET_PC, 200);
    cyc = 0; ho = 0; busy_cnt = 0;
    redir_cycle = -1; req_chk_cycle = -1;
    stall = 1'b0; rand_ready = 1'b0; jump_armed = 1'b0; chk_ahead = 1'b0;
    prev_stalled = 1'b0; want_first = 1'b0; first_pc = 32'hDEAD_BEEF;
    #1;
    check("post_rst_req_valid", 32'(IMEM_REQ_VALID), 32'd1);
    check("post_rst_addr", IMEM_REQ_ADDR, RESET_PC);
  endtask

  initial begin
    RST = 1'b1; jump_tgt = 32'h0; jump_pc = 32'h0; lat = 1; redir_delay = 0;
    @(negedge CLK);

    // Streaming with a one-cycle memory: back-to-back handovers from RESET_PC.
    do_reset();
    lat = 1; chk_ahead = 1'b1;
    run_cycles(20);
    check("t1_handovers", 32'(ho), 32'd18);

    // Downstream hold fills the FIFO and exhausts credits; stream resumes intact.
    stall = 1'b1;
    run_cycles(10);
    check("t2_full_req_valid", 32'(IMEM_REQ_VALID), 32'd0);
    stall = 1'b0; ho = 0;
    run_cycles(15);
    check("t2_resume_handovers", 32'(ho), 32'd15);
    chk_ahead = 1'b0;

    // Taken jump at 0x8 with reads in flight, redirect four cycles later.
    do_reset();
    lat = 3; jump_pc = 32'h8; jump_tgt = 32'h100; redir_delay = 4; jump_armed = 1'b1;
    run_cycles(40);
    check("t3_busy_cycles", 32'(busy_cnt), 32'd4);
    check("t3_first_pc", first_pc, 32'h100);

    // Not-taken branch at 0x20 redirects to the fall-through 0x24.
    do_reset();
    lat = 1; jump_pc = 32'h20; jump_tgt = 32'h24; redir_delay = 2; jump_armed = 1'b1;
    run_cycles(30);
    check("t4_busy_cycles", 32'(busy_cnt), 32'd2);
    check("t4_first_pc", first_pc, 32'h24);

    // Random request backpressure with a three-cycle memory.
    do_reset();
    lat = 3; rand_ready = 1'b1;
    run_cycles(80);
    rand_ready = 1'b0;
    check("t5_progress", 32'(ho >= 10), 32'd1);

    // Reset while waiting for a redirect with stale reads outstanding.
    do_reset();
    lat = 3; jump_pc = 32'h10; jump_tgt = 32'h200; redir_delay = 1000; jump_armed = 1'b1;
    for (int i = 0; i < 60 && !BUSY_WAIT; i++) run_cycles(1);
    check("t6_in_wait", 32'(BUSY_WAIT), 32'd1);
    check("t6_inflight", 32'(mem_q.size() > 0), 32'd1);
    do_reset();
    lat = 3;
    run_cycles(20);
    check("t6_restart_progress", 32'(ho >= 10), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
